// File: rtl/sort_stream_unloader.sv
// Buffers sorted vectors from the non-stallable bitonic sorter and streams them
// out one element per cycle on a valid/ready interface, flagging dropped vectors.
module sort_stream_unloader #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BUF_VECS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vec_valid_in,
    input  logic [0:WIDTH-1]   vec_in [0:DEPTH-1],
    output logic               vec_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               overflow
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (BUF_VECS > 1) ? $clog2(BUF_VECS) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_VECS) + 1;

    logic [WIDTH-1:0] mem_q [BUF_VECS][DEPTH];

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic             vec_ready_q, vec_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             xfer;
    logic             release_vec;
    logic             wr_en;
    logic [WIDTH-1:0] head_word;

    // Next state; outputs are precomputed from next state so they leave a flop.
    always_comb begin
        xfer        = out_valid_q && out_ready;
        release_vec = xfer && (idx_q == IDX_W'(DEPTH - 1));
        wr_en       = vec_valid_in && ((cnt_q < CNT_W'(BUF_VECS)) || release_vec);

        idx_d      = idx_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q || (vec_valid_in && !wr_en);

        if (xfer) begin
            idx_d = release_vec ? '0 : idx_q + IDX_W'(1);
        end
        if (release_vec) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_VECS - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_VECS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (wr_en && !release_vec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!wr_en && release_vec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // The slot being written becomes the head only when nothing else is queued.
        if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            head_word = vec_in[idx_d];
        end else begin
            head_word = mem_q[rd_ptr_d][idx_d];
        end

        out_valid_d = (cnt_d != '0);
        out_data_d  = out_valid_d ? head_word : '0;
        out_last_d  = out_valid_d && (idx_d == IDX_W'(DEPTH - 1));
        vec_ready_d = (cnt_d < CNT_W'(BUF_VECS));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            vec_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            vec_ready_q <= vec_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Vector storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[wr_ptr_q][i] <= vec_in[i];
            end
        end
    end

    assign vec_ready = vec_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sort_stream_unloader.sv
// Randomized bench for sort_stream_unloader against a queue-of-vectors reference model.
module tb_sort_stream_unloader;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned BUF_VECS = 2;

    typedef logic [WIDTH-1:0] vec_t [DEPTH];

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             vec_valid_in = 1'b0;
    logic [0:WIDTH-1] vec_in [0:DEPTH-1];
    logic             vec_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             overflow;

    sort_stream_unloader #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .BUF_VECS (BUF_VECS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vec_valid_in (vec_valid_in),
        .vec_in       (vec_in),
        .vec_ready    (vec_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    vec_t mq[$];
    int   m_idx = 0;
    bit   m_ovf = 1'b0;
    int   n_drops = 0;
    int   n_collide = 0;
    int   n_resets = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit          e_valid;
        logic [31:0] e_data;
        e_valid = (mq.size() != 0);
        e_data  = e_valid ? mq[0][m_idx] : '0;
        check_eq("out_valid", 64'(out_valid), 64'(e_valid));
        check_eq("out_data",  64'(out_data),  64'(e_data));
        check_eq("out_last",  64'(out_last),  64'(e_valid && (m_idx == int'(DEPTH) - 1)));
        check_eq("vec_ready", 64'(vec_ready), 64'(mq.size() < int'(BUF_VECS)));
        check_eq("overflow",  64'(overflow),  64'(m_ovf));
    endtask

    task automatic load_random_vector();
        logic [WIDTH-1:0] v;
        v = WIDTH'($urandom_range(0, 100000));
        for (int i = 0; i < int'(DEPTH); i++) begin
            vec_in[i] = v;
            v = v + WIDTH'($urandom_range(0, 5000));
        end
    endtask

    // Spec-level model: release of the head first, then admission of the new vector.
    task automatic model_edge();
        bit   xfer;
        bit   rel;
        vec_t v;
        if (!rst) begin
            mq.delete();
            m_idx = 0;
            m_ovf = 1'b0;
            return;
        end
        xfer = (mq.size() != 0) && out_ready;
        rel  = xfer && (m_idx == int'(DEPTH) - 1);
        if (xfer) m_idx = rel ? 0 : m_idx + 1;
        if (rel) void'(mq.pop_front());
        if (vec_valid_in) begin
            if (rel && mq.size() == int'(BUF_VECS) - 1) n_collide++;
            if (mq.size() < int'(BUF_VECS)) begin
                for (int i = 0; i < int'(DEPTH); i++) v[i] = vec_in[i];
                mq.push_back(v);
            end else begin
                m_ovf = 1'b1;
                n_drops++;
            end
        end
    endtask

    // mode 0: random, 1: sustained pulse every DEPTH cycles, 2: force full+release collisions
    task automatic run_phase(input int cycles, input int p_pulse, input int p_ready,
                             input int p_rst, input int mode);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            compare_outputs();
            rst          = ($urandom_range(0, 999) >= p_rst * 10);
            out_ready    = ($urandom_range(0, 99) < p_ready);
            vec_valid_in = 1'b0;
            case (mode)
                1: vec_valid_in = (c % int'(DEPTH) == 0);
                2: vec_valid_in = (mq.size() == int'(BUF_VECS) && out_ready &&
                                   m_idx == int'(DEPTH) - 1) ||
                                  ($urandom_range(0, 99) < p_pulse);
                default: vec_valid_in = ($urandom_range(0, 99) < p_pulse);
            endcase
            if (vec_valid_in) load_random_vector();
            if (!rst) n_resets++;
            @(posedge clk);
            model_edge();
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) vec_in[i] = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        model_edge();

        run_phase(400, 0, 100, 0, 1);
        run_phase(600, 20, 70, 0, 0);
        run_phase(500, 40, 15, 0, 0);
        run_phase(600, 10, 90, 0, 2);
        run_phase(600, 25, 60, 2, 0);
        run_phase(300, 60, 5, 0, 0);
        run_phase(100, 0, 100, 0, 0);

        @(negedge clk);
        compare_outputs();
        rst = 1'b1;
        check_eq("drops_seen", 64'(n_drops != 0), 64'(1));
        check_eq("collisions_seen", 64'(n_collide != 0), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
